wb_regfile: RTL and testbench

- Write-back end of the MEM/WB interface: the 32-entry MIPS general register file.
- Consumes the WB-stage regwrite / write-address / write-data / pc triplet produced by the MEM/WB pipeline register.
- Serves two read ports to the ID stage, with write-to-read bypass so ID sees same-cycle WB results.
- Keeps a retire counter and a last-committed-pc register for debug.

---
 rtl/wb_regfile.sv | 130 +++++++++++++
 tb/tb_wb_regfile.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// MIPS 32-entry general register file at the MEM/WB boundary, with write-to-read bypass and debug counters.
// Optional macro WB_REGFILE_TRACE_EN adds a registered commit trace port set.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_regwrite,
    input  logic [31:0]       wb_pc,
    input  logic [ADDR_W-1:0] wb_wbadd,
    input  logic [DATA_W-1:0] wb_wbdata,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [31:0]       retire_cnt,
    output logic [31:0]       last_wb_pc
`ifdef WB_REGFILE_TRACE_EN
    ,
    output logic [31:0]       debug_wb_pc,
    output logic              debug_wb_rf_wen,
    output logic [ADDR_W-1:0] debug_wb_rf_wnum,
    output logic [DATA_W-1:0] debug_wb_rf_wdata
`endif
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [1:DEPTH-1];
    logic [31:0]       retire_cnt_q, retire_cnt_d;
    logic [31:0]       last_pc_q, last_pc_d;
    logic              commit;

    // Gating with reset also kills bypass while the array is held clear.
    assign commit = wb_regwrite && (wb_wbadd != '0) && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit) begin
            regs_q[wb_wbadd] <= wb_wbdata;
        end
    end

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        last_pc_d    = last_pc_q;
        if (commit) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
            last_pc_d    = wb_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_cnt_q <= '0;
            last_pc_q    <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
            last_pc_q    <= last_pc_d;
        end
    end

    assign retire_cnt = retire_cnt_q;
    assign last_wb_pc = last_pc_q;

    always_comb begin
        rs_data = '0;
        if (rs_addr != '0) begin
            if ((BYPASS != 0) && commit && (rs_addr == wb_wbadd)) begin
                rs_data = wb_wbdata;
            end else begin
                rs_data = regs_q[rs_addr];
            end
        end
    end

    always_comb begin
        rt_data = '0;
        if (rt_addr != '0) begin
            if ((BYPASS != 0) && commit && (rt_addr == wb_wbadd)) begin
                rt_data = wb_wbdata;
            end else begin
                rt_data = regs_q[rt_addr];
            end
        end
    end

`ifdef WB_REGFILE_TRACE_EN
    logic [31:0]       dbg_pc_q, dbg_pc_d;
    logic              dbg_wen_q;
    logic [ADDR_W-1:0] dbg_wnum_q, dbg_wnum_d;
    logic [DATA_W-1:0] dbg_wdata_q, dbg_wdata_d;

    always_comb begin
        dbg_pc_d    = dbg_pc_q;
        dbg_wnum_d  = dbg_wnum_q;
        dbg_wdata_d = dbg_wdata_q;
        if (commit) begin
            dbg_pc_d    = wb_pc;
            dbg_wnum_d  = wb_wbadd;
            dbg_wdata_d = wb_wbdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dbg_pc_q    <= '0;
            dbg_wen_q   <= 1'b0;
            dbg_wnum_q  <= '0;
            dbg_wdata_q <= '0;
        end else begin
            dbg_pc_q    <= dbg_pc_d;
            dbg_wen_q   <= commit;
            dbg_wnum_q  <= dbg_wnum_d;
            dbg_wdata_q <= dbg_wdata_d;
        end
    end

    assign debug_wb_pc       = dbg_pc_q;
    assign debug_wb_rf_wen   = dbg_wen_q;
    assign debug_wb_rf_wnum  = dbg_wnum_q;
    assign debug_wb_rf_wdata = dbg_wdata_q;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: one bypassing instance and one non-bypassing instance share stimulus.
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic        wb_regwrite;
    logic [31:0] wb_pc;
    logic [4:0]  wb_wbadd;
    logic [31:0] wb_wbdata;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data, rt_data, retire_cnt, last_wb_pc;
    logic [31:0] rs_data0, rt_data0, retire_cnt0, last_wb_pc0;

    int checks = 0;
    int errors = 0;

`ifdef WB_REGFILE_TRACE_EN
    logic [31:0] debug_wb_pc, debug_wb_pc0;
    logic        debug_wb_rf_wen, debug_wb_rf_wen0;
    logic [4:0]  debug_wb_rf_wnum, debug_wb_rf_wnum0;
    logic [31:0] debug_wb_rf_wdata, debug_wb_rf_wdata0;
`endif

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .wb_regwrite(wb_regwrite), .wb_pc(wb_pc),
        .wb_wbadd(wb_wbadd), .wb_wbdata(wb_wbdata), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data), .retire_cnt(retire_cnt), .last_wb_pc(last_wb_pc)
`ifdef WB_REGFILE_TRACE_EN
        , .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
`endif
    );

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut0 (
        .clk(clk), .reset(reset), .wb_regwrite(wb_regwrite), .wb_pc(wb_pc),
        .wb_wbadd(wb_wbadd), .wb_wbdata(wb_wbdata), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data0), .rt_data(rt_data0), .retire_cnt(retire_cnt0), .last_wb_pc(last_wb_pc0)
`ifdef WB_REGFILE_TRACE_EN
        , .debug_wb_pc(debug_wb_pc0), .debug_wb_rf_wen(debug_wb_rf_wen0),
        .debug_wb_rf_wnum(debug_wb_rf_wnum0), .debug_wb_rf_wdata(debug_wb_rf_wdata0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives a commit at the negedge, lets one rising edge take it, then drops regwrite.
    task automatic do_commit(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        @(negedge clk);
        wb_regwrite = 1'b1;
        wb_wbadd    = a;
        wb_wbdata   = d;
        wb_pc       = pc;
        @(posedge clk);
        #1;
        wb_regwrite = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wb_regwrite = 1'b0; wb_pc = '0; wb_wbadd = '0; wb_wbdata = '0;
        rs_addr = 5'd5; rt_addr = 5'd31;
        #3;
        checks++;
        if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_reads rs=%h rt=%h expected 0", rs_data, rt_data);
        end
        checks++;
        if (retire_cnt !== 32'h0 || last_wb_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_counters retire=%h pc=%h expected 0", retire_cnt, last_wb_pc);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic_write();
        @(negedge clk);
        rs_addr = 5'd5;
        wb_regwrite = 1'b1; wb_wbadd = 5'd5; wb_wbdata = 32'hDEADBEEF; wb_pc = 32'h0040_0010;
        #1;
        checks++;
        if (rs_data0 !== 32'h0) begin
            errors++;
            $display("FAIL nobypass_before_edge rs=%h expected 00000000", rs_data0);
        end
        @(posedge clk);
        #1;
        wb_regwrite = 1'b0;
        #1;
        checks++;
        if (rs_data !== 32'hDEADBEEF || rs_data0 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL basic_read rs=%h rs0=%h expected deadbeef", rs_data, rs_data0);
        end
        checks++;
        if (retire_cnt !== 32'd1 || last_wb_pc !== 32'h0040_0010) begin
            errors++;
            $display("FAIL basic_counters retire=%h pc=%h expected 1/00400010", retire_cnt, last_wb_pc);
        end
    endtask

    task automatic test_r0();
        @(negedge clk);
        rs_addr = 5'd0;
        wb_regwrite = 1'b1; wb_wbadd = 5'd0; wb_wbdata = 32'h12345678; wb_pc = 32'h0040_0014;
        #1;
        checks++;
        if (rs_data !== 32'h0) begin
            errors++;
            $display("FAIL r0_bypass rs=%h expected 00000000", rs_data);
        end
        @(posedge clk);
        #1;
        wb_regwrite = 1'b0;
        #1;
        checks++;
        if (rs_data !== 32'h0 || retire_cnt !== 32'd1 || last_wb_pc !== 32'h0040_0010) begin
            errors++;
            $display("FAIL r0_write rs=%h retire=%h pc=%h expected 0/1/00400010", rs_data, retire_cnt, last_wb_pc);
        end
    endtask

    task automatic test_bypass();
        do_commit(5'd7, 32'h11111111, 32'h0040_0018);
        @(negedge clk);
        rs_addr = 5'd7; rt_addr = 5'd7;
        wb_regwrite = 1'b1; wb_wbadd = 5'd7; wb_wbdata = 32'hA5A5A5A5; wb_pc = 32'h0040_001C;
        #1;
        checks++;
        if (rs_data !== 32'hA5A5A5A5 || rt_data !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL bypass_on rs=%h rt=%h expected a5a5a5a5", rs_data, rt_data);
        end
        checks++;
        if (rs_data0 !== 32'h11111111 || rt_data0 !== 32'h11111111) begin
            errors++;
            $display("FAIL bypass_off_before rs=%h rt=%h expected 11111111", rs_data0, rt_data0);
        end
        @(posedge clk);
        #1;
        wb_regwrite = 1'b0;
        #1;
        checks++;
        if (rs_data0 !== 32'hA5A5A5A5 || rt_data0 !== 32'hA5A5A5A5 || retire_cnt !== 32'd3) begin
            errors++;
            $display("FAIL bypass_off_after rs=%h rt=%h retire=%h expected a5a5a5a5/a5a5a5a5/3",
                     rs_data0, rt_data0, retire_cnt);
        end
    endtask

    task automatic test_gating();
        @(negedge clk);
        rs_addr = 5'd9; rt_addr = 5'd5;
        wb_regwrite = 1'b0; wb_wbadd = 5'd9; wb_wbdata = 32'hCAFEF00D; wb_pc = 32'h0040_0050;
        #1;
        checks++;
        if (rs_data !== 32'h0) begin
            errors++;
            $display("FAIL gating_bypass rs=%h expected 00000000", rs_data);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rs_data !== 32'h0 || rt_data !== 32'hDEADBEEF || retire_cnt !== 32'd3 || last_wb_pc !== 32'h0040_001C) begin
            errors++;
            $display("FAIL gating_hold rs=%h rt=%h retire=%h pc=%h expected 0/deadbeef/3/0040001c",
                     rs_data, rt_data, retire_cnt, last_wb_pc);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        wb_regwrite = 1'b1; wb_wbadd = 5'd1; wb_wbdata = 32'h0000_0101; wb_pc = 32'h0040_0060;
        @(negedge clk);
        wb_wbadd = 5'd2; wb_wbdata = 32'h0000_0202; wb_pc = 32'h0040_0064;
        @(posedge clk);
        #1;
        wb_regwrite = 1'b0;
        rs_addr = 5'd1; rt_addr = 5'd2;
        #1;
        checks++;
        if (rs_data !== 32'h0000_0101 || rt_data !== 32'h0000_0202) begin
            errors++;
            $display("FAIL b2b_reads rs=%h rt=%h expected 00000101/00000202", rs_data, rt_data);
        end
        checks++;
        if (retire_cnt !== 32'd5 || last_wb_pc !== 32'h0040_0064) begin
            errors++;
            $display("FAIL b2b_counters retire=%h pc=%h expected 5/00400064", retire_cnt, last_wb_pc);
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt_q;
        #1;
        checks++;
        if (retire_cnt !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_preload retire=%h expected ffffffff", retire_cnt);
        end
        do_commit(5'd3, 32'h0000_0033, 32'h0040_0070);
        #1;
        checks++;
        if (retire_cnt !== 32'h0 || retire_cnt0 !== 32'd6) begin
            errors++;
            $display("FAIL wrap retire=%h retire0=%h expected 0/6", retire_cnt, retire_cnt0);
        end
    endtask

`ifdef WB_REGFILE_TRACE_EN
    task automatic test_trace();
        do_commit(5'd31, 32'h0000_BEEF, 32'h0040_0100);
        checks++;
        if (debug_wb_rf_wen !== 1'b1 || debug_wb_rf_wnum !== 5'd31 ||
            debug_wb_rf_wdata !== 32'h0000_BEEF || debug_wb_pc !== 32'h0040_0100) begin
            errors++;
            $display("FAIL trace_commit wen=%b wnum=%0d wdata=%h pc=%h expected 1/31/0000beef/00400100",
                     debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata, debug_wb_pc);
        end
        @(posedge clk);
        #1;
        checks++;
        if (debug_wb_rf_wen !== 1'b0 || debug_wb_rf_wnum !== 5'd31 || debug_wb_rf_wdata !== 32'h0000_BEEF) begin
            errors++;
            $display("FAIL trace_idle wen=%b wnum=%0d wdata=%h expected 0/31/0000beef",
                     debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata);
        end
    endtask
`endif

    task automatic test_reset_mid();
        int bad;
        @(negedge clk);
        wb_regwrite = 1'b1; wb_wbadd = 5'd5; wb_wbdata = 32'h7777_7777; wb_pc = 32'h0040_0200;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        bad = 0;
        for (int a = 0; a < 32; a++) begin
            rs_addr = 5'(a);
            rt_addr = 5'(31 - a);
            #1;
            if (rs_data !== 32'h0 || rt_data !== 32'h0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_mid_reads nonzero_reads=%0d expected 0", bad);
        end
        checks++;
        if (retire_cnt !== 32'h0 || last_wb_pc !== 32'h0 || retire_cnt0 !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_counters retire=%h pc=%h retire0=%h expected 0", retire_cnt, last_wb_pc, retire_cnt0);
        end
        rs_addr = 5'd5;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        wb_regwrite = 1'b0;
        #1;
        checks++;
        if (rs_data !== 32'h7777_7777 || retire_cnt !== 32'd1 || last_wb_pc !== 32'h0040_0200) begin
            errors++;
            $display("FAIL first_commit_after_reset rs=%h retire=%h pc=%h expected 77777777/1/00400200",
                     rs_data, retire_cnt, last_wb_pc);
        end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_r0();
        test_bypass();
        test_gating();
        test_back_to_back();
        test_wrap();
`ifdef WB_REGFILE_TRACE_EN
        test_trace();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
